pu_block_mac: RTL

- Processing unit of the coprocessor.
- Accepts a 2x2 A block and a 2x2 B block from the register-file read path, computes the block product with one shared multiplier, and accumulates it into four partial-sum registers.
- Sits directly downstream of the control unit: it consumes PU_Start and drives Partial_Output_Ready back to the CU, which then writes the partial result to memory.

---
 rtl/pu_block_mac.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pu_block_mac.sv
// pu_block_mac -- 2x2 block multiply-accumulate processing unit.
//
// Latches a 2x2 A block and a 2x2 B block when a start is accepted. It then
// runs eight multiply-accumulate steps through a single shared signed
// multiplier. The results are added into four signed accumulators.
//
// Ports:
//   i_Clock                 rising-edge clock
//   i_Reset                 asynchronous active-high reset
//   i_PU_Start              start request; accepted in IDLE or DONE
//   i_Clear_Acc             with an accepted start: zero accumulators first
//   i_A_Flat, i_B_Flat      operand blocks, element (i,j) at [(2i+j)*DATA_W +: DATA_W]
//   o_C_Flat                accumulators, element (i,j) at [(2i+j)*ACC_W +: ACC_W]
//   o_Partial_Output_Ready  level, high in DONE (result valid)
//   o_Busy                  high while the multiply sequence runs
module pu_block_mac #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 72
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_PU_Start,
  input  logic                i_Clear_Acc,
  input  logic [4*DATA_W-1:0] i_A_Flat,
  input  logic [4*DATA_W-1:0] i_B_Flat,
  output logic [4*ACC_W-1:0]  o_C_Flat,
  output logic                o_Partial_Output_Ready,
  output logic                o_Busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [2:0]              step_reg;
  logic [DATA_W-1:0]       a_reg   [4];
  logic [DATA_W-1:0]       b_reg   [4];
  logic [ACC_W-1:0]        acc_reg [4];

  logic                    start_accept;
  logic                    mul_active;
  logic [1:0]              elem_idx;
  logic                    row_sel;
  logic                    col_sel;
  logic                    term_sel;
  logic signed [DATA_W-1:0]   a_sel;
  logic signed [DATA_W-1:0]   b_sel;
  logic signed [2*DATA_W-1:0] product;
  logic [ACC_W-1:0]           product_ext;

  assign start_accept = i_PU_Start && (state_reg != ST_MUL);
  assign mul_active   = (state_reg == ST_MUL);

  // Step encoding: step[2:1] is the output element e = 2i+j.
  // step[0] is the inner-product term t.
  assign elem_idx = step_reg[2:1];
  assign row_sel  = step_reg[2];
  assign col_sel  = step_reg[1];
  assign term_sel = step_reg[0];

  // A[i][t] and B[t][j] feed the single shared multiplier.
  assign a_sel       = $signed(a_reg[{row_sel, term_sel}]);
  assign b_sel       = $signed(b_reg[{term_sel, col_sel}]);
  assign product     = a_sel * b_sel;
  assign product_ext = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (i_PU_Start) state_next = ST_MUL;
      ST_MUL:  if (step_reg == 3'd7) state_next = ST_DONE;
      ST_DONE: if (i_PU_Start) state_next = ST_MUL;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_Busy                 = 1'b0;
    o_Partial_Output_Ready = 1'b0;
    case (state_reg)
      ST_MUL:  o_Busy = 1'b1;
      ST_DONE: o_Partial_Output_Ready = 1'b1;
      default: ;
    endcase
  end

  // Step counter. It wraps 7 -> 0 on the final accumulate.
  // A new start also forces it to 0.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      step_reg <= 3'd0;
    end else if (start_accept) begin
      step_reg <= 3'd0;
    end else if (mul_active) begin
      step_reg <= step_reg + 3'd1;
    end
  end

  // Per-element operand latches and accumulators.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_elem
      always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
          a_reg[gi] <= '0;
          b_reg[gi] <= '0;
        end else if (start_accept) begin
          a_reg[gi] <= i_A_Flat[gi*DATA_W +: DATA_W];
          b_reg[gi] <= i_B_Flat[gi*DATA_W +: DATA_W];
        end
      end

      // Each accumulator only updates on the two steps that target it.
      always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
          acc_reg[gi] <= '0;
        end else if (start_accept) begin
          if (i_Clear_Acc) acc_reg[gi] <= '0;
        end else if (mul_active && (elem_idx == 2'(gi))) begin
          acc_reg[gi] <= acc_reg[gi] + product_ext;
        end
      end

      assign o_C_Flat[gi*ACC_W +: ACC_W] = acc_reg[gi];
    end
  endgenerate

endmodule
